// File: rtl/hub75_scan_ctrl.sv
// HUB75 1/32-scan panel sequencer: reads the image ROM, shifts bit planes and times OE with BCM.
// Optional build macro SCAN_BRIGHTNESS_EN adds a brightness[3:0] input that trims OE time.
module hub75_scan_ctrl #(
  parameter int COLS       = 64,
  parameter int ROWS_HALF  = 32,
  parameter int BPC        = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int BASE_ON    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [3:0]            brightness,
`endif
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]           rom_data,
  output logic                  pan_r0,
  output logic                  pan_g0,
  output logic                  pan_b0,
  output logic                  pan_r1,
  output logic                  pan_g1,
  output logic                  pan_b1,
  output logic                  pan_clk,
  output logic                  pan_lat,
  output logic                  pan_oe_n,
  output logic [4:0]            pan_row,
  output logic                  frame_start
);

  // state    | meaning
  // IDLE     | panel dark, waiting for enable
  // PREFETCH | first ROM address of the row issued
  // SHIFT    | two cycles per column: data setup, then pan_clk high
  // BLANK    | OE off, row address updated
  // LATCH    | shifted plane transferred to panel drivers
  // DISPLAY  | OE on for BASE_ON<<plane cycles
  typedef enum logic [2:0] {S_IDLE, S_PREFETCH, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY} state_t;

  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS_HALF);
  localparam int PL_W   = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DISP_W = $clog2((BASE_ON << (BPC - 1)) + 1);

  state_t            state, state_nx;
  logic [ROW_W-1:0]  row;
  logic [PL_W-1:0]   plane;
  logic [COL_W-1:0]  col, col_addr;
  logic              phase;
  logic [DISP_W-1:0] disp_cnt, dur;
  logic              frame_pend, oe_on;
  logic              last_col, last_plane, last_row, disp_done;
  logic [3:0]        nib_r0, nib_g0, nib_b0, nib_r1, nib_g1, nib_b1;

  assign dur        = DISP_W'(BASE_ON) << plane;
  assign last_col   = (col == COL_W'(COLS - 1));
  assign last_plane = (plane == PL_W'(BPC - 1));
  assign last_row   = (row == ROW_W'(ROWS_HALF - 1));
  assign disp_done  = (disp_cnt == '0);

  assign nib_b0 = rom_data[3:0];
  assign nib_g0 = rom_data[7:4];
  assign nib_r0 = rom_data[11:8];
  assign nib_b1 = rom_data[15:12];
  assign nib_g1 = rom_data[19:16];
  assign nib_r1 = rom_data[23:20];

`ifdef SCAN_BRIGHTNESS_EN
  logic [3:0]        bright_q;
  logic [DISP_W+3:0] on_prod;
  logic [DISP_W-1:0] on_len;

  // disp_cnt counts down, so "elapsed < on_len" becomes "remaining >= dur - on_len"
  assign on_prod = {4'b0, dur} * {{(DISP_W - 1){1'b0}}, {1'b0, bright_q} + 5'd1};
  assign on_len  = DISP_W'(on_prod >> 4);
  assign oe_on   = (disp_cnt >= (dur - on_len));
`else
  assign oe_on = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    pan_clk     = 1'b0;
    pan_lat     = 1'b0;
    pan_oe_n    = 1'b1;
    frame_start = 1'b0;
    col_addr    = col;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nx    = S_PREFETCH;
          frame_start = (row == '0) && (plane == '0);
        end
      end
      S_PREFETCH: begin
        state_nx    = S_SHIFT;
        frame_start = frame_pend;
      end
      S_SHIFT: begin
        pan_clk = phase;
        if (phase) begin
          if (last_col) state_nx = S_BLANK;
          else          col_addr = col + 1'b1;
        end
      end
      S_BLANK:  state_nx = S_LATCH;
      S_LATCH: begin
        pan_lat  = 1'b1;
        state_nx = S_DISPLAY;
      end
      S_DISPLAY: begin
        pan_oe_n = !oe_on;
        if (disp_done) state_nx = enable ? S_PREFETCH : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    rom_addr = {row, col_addr};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row        <= '0;
      plane      <= '0;
      col        <= '0;
      phase      <= 1'b0;
      disp_cnt   <= '0;
      frame_pend <= 1'b0;
      pan_row    <= '0;
      pan_r0     <= 1'b0;
      pan_g0     <= 1'b0;
      pan_b0     <= 1'b0;
      pan_r1     <= 1'b0;
      pan_g1     <= 1'b0;
      pan_b1     <= 1'b0;
`ifdef SCAN_BRIGHTNESS_EN
      bright_q   <= 4'hF;
`endif
    end else begin
      case (state)
        S_PREFETCH: begin
          col        <= '0;
          phase      <= 1'b0;
          frame_pend <= 1'b0;
        end
        S_SHIFT: begin
          phase <= ~phase;
          if (!phase) begin
            pan_r0 <= nib_r0[plane];
            pan_g0 <= nib_g0[plane];
            pan_b0 <= nib_b0[plane];
            pan_r1 <= nib_r1[plane];
            pan_g1 <= nib_g1[plane];
            pan_b1 <= nib_b1[plane];
          end else if (last_col) begin
            col <= '0;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_BLANK: begin
          pan_row <= row;
`ifdef SCAN_BRIGHTNESS_EN
          bright_q <= brightness;
`endif
        end
        S_LATCH: disp_cnt <= dur - 1'b1;
        S_DISPLAY: begin
          if (!disp_done) begin
            disp_cnt <= disp_cnt - 1'b1;
          end else begin
            frame_pend <= enable && last_plane && last_row;
            if (last_plane) begin
              plane <= '0;
              row   <= last_row ? '0 : row + 1'b1;
            end else begin
              plane <= plane + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Self-checking bench for hub75_scan_ctrl: ROM model, per-column data scoreboard, BCM and frame timing.
module tb_hub75_scan_ctrl;
  localparam int COLS      = 64;
  localparam int ROWS_HALF = 32;
  localparam int BASE_ON   = 32;
  localparam int FRAME_LEN = 32128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic        pan_r0, pan_g0, pan_b0, pan_r1, pan_g1, pan_b1;
  logic        pan_clk, pan_lat, pan_oe_n, frame_start;
  logic [4:0]  pan_row;
`ifdef SCAN_BRIGHTNESS_EN
  logic [3:0]  brightness = 4'd15;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_now  = 0;
  int t_pref0  = 0;
  int rom_mode = 0;
  logic [5:0] sb[$];

  always #5 clk = ~clk;

  hub75_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
`ifdef SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pan_r0(pan_r0), .pan_g0(pan_g0), .pan_b0(pan_b0),
    .pan_r1(pan_r1), .pan_g1(pan_g1), .pan_b1(pan_b1),
    .pan_clk(pan_clk), .pan_lat(pan_lat), .pan_oe_n(pan_oe_n),
    .pan_row(pan_row), .frame_start(frame_start)
  );

  function automatic logic [23:0] rom_word(input logic [10:0] a, input int mode);
    if (mode == 0) return 24'hF0A5C3;
    return {1'b0, a, ~a, 1'b1};
  endfunction

  // Image ROM with one-cycle synchronous read
  always @(posedge clk) rom_data <= rom_word(rom_addr, rom_mode);

  function automatic logic [5:0] slice(input logic [23:0] w, input int p);
    return {w[8+p], w[4+p], w[p], w[20+p], w[16+p], w[12+p]};
  endfunction

  function automatic int exp_on_cycles(input int p);
`ifdef SCAN_BRIGHTNESS_EN
    return ((BASE_ON << p) * (int'(brightness) + 1)) >> 4;
`else
    return BASE_ON << p;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc_now++;
  endtask

  // Precondition: current sample is the PREFETCH cycle of (row, plane).
  task automatic check_rowplane(input int row, input int plane, input int exp_on,
                                input logic exp_fs, input int drop_at);
    int nrise, lat_cyc, data_err, addr_err, oe_err, row_err, on_cnt, bad_col;
    logic prev_clk;
    logic [5:0] exp_d, got_d, bad_got, bad_exp;
    logic [10:0] exp_a;
    nrise = 0; lat_cyc = -1; data_err = 0; addr_err = 0; oe_err = 0; row_err = 0;
    on_cnt = 0; bad_col = -1; bad_got = '0; bad_exp = '0;

    n_checks++;
    if (rom_addr !== 11'(row * COLS)) $display("FAIL prefetch_addr r%0d p%0d got %h want %h", row, plane, rom_addr, 11'(row * COLS));
    else n_pass++;
    n_checks++;
    if (frame_start !== exp_fs) $display("FAIL frame_start r%0d p%0d got %b want %b", row, plane, frame_start, exp_fs);
    else n_pass++;

    for (int c = 0; c < COLS; c++) sb.push_back(slice(rom_word(11'(row * COLS + c), rom_mode), plane));

    prev_clk = pan_clk;
    for (int cyc = 1; cyc <= 300 && lat_cyc < 0; cyc++) begin
      tick();
      if (pan_oe_n !== 1'b1) oe_err++;
      if (pan_lat === 1'b1) lat_cyc = cyc;
      if (pan_clk === 1'b1 && prev_clk === 1'b0) begin
        exp_a = 11'(row * COLS + ((nrise >= COLS - 1) ? COLS - 1 : nrise + 1));
        if (rom_addr !== exp_a) addr_err++;
        got_d = {pan_r0, pan_g0, pan_b0, pan_r1, pan_g1, pan_b1};
        if (sb.size() > 0) begin
          exp_d = sb.pop_front();
          if (got_d !== exp_d) begin
            if (bad_col < 0) begin bad_col = nrise; bad_got = got_d; bad_exp = exp_d; end
            data_err++;
          end
        end else begin
          data_err++;
        end
        nrise++;
        if (nrise == drop_at) enable = 1'b0;
      end
      prev_clk = pan_clk;
    end

    n_checks++;
    if (lat_cyc != 130) $display("FAIL latch_cycle r%0d p%0d got %0d want 130", row, plane, lat_cyc);
    else n_pass++;
    n_checks++;
    if (nrise != COLS) $display("FAIL clk_rises r%0d p%0d got %0d want %0d", row, plane, nrise, COLS);
    else n_pass++;
    n_checks++;
    if (data_err != 0 || sb.size() != 0)
      $display("FAIL shift_data r%0d p%0d errors %0d first col %0d got %b want %b left %0d",
               row, plane, data_err, bad_col, bad_got, bad_exp, sb.size());
    else n_pass++;
    sb.delete();
    n_checks++;
    if (addr_err != 0) $display("FAIL shift_addr r%0d p%0d got %0d bad addresses want 0", row, plane, addr_err);
    else n_pass++;
    n_checks++;
    if (oe_err != 0) $display("FAIL oe_before_display r%0d p%0d got %0d active cycles want 0", row, plane, oe_err);
    else n_pass++;

    for (int i = 0; i < (BASE_ON << plane); i++) begin
      tick();
      if (pan_oe_n === 1'b0) begin
        on_cnt++;
        if (pan_row !== 5'(row)) row_err++;
      end
    end
    n_checks++;
    if (on_cnt != exp_on) $display("FAIL oe_cycles r%0d p%0d got %0d want %0d", row, plane, on_cnt, exp_on);
    else n_pass++;
    n_checks++;
    if (row_err != 0 || pan_row !== 5'(row)) $display("FAIL pan_row r%0d p%0d got %0d (unstable %0d) want %0d", row, plane, pan_row, row_err, row);
    else n_pass++;

    tick();
    n_checks++;
    if (pan_oe_n !== 1'b1) $display("FAIL oe_after_display r%0d p%0d got %b want 1", row, plane, pan_oe_n);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (pan_oe_n !== 1'b1) $display("FAIL reset_oe got %b want 1", pan_oe_n); else n_pass++;
    n_checks++;
    if ({pan_clk, pan_lat, frame_start} !== 3'b000) $display("FAIL reset_ctl got %b want 000", {pan_clk, pan_lat, frame_start}); else n_pass++;
    n_checks++;
    if (rom_addr !== 11'd0 || pan_row !== 5'd0) $display("FAIL reset_addr got addr %h row %0d want 0 0", rom_addr, pan_row); else n_pass++;
    n_checks++;
    if ({pan_r0, pan_g0, pan_b0, pan_r1, pan_g1, pan_b1} !== 6'd0)
      $display("FAIL reset_data got %b want 000000", {pan_r0, pan_g0, pan_b0, pan_r1, pan_g1, pan_b1});
    else n_pass++;
    rst_n = 1'b1; enable = 1'b1;
    #1;
    n_checks++;
    if (frame_start !== 1'b1) $display("FAIL first_frame_start got %b want 1", frame_start); else n_pass++;
    tick();
    t_pref0 = cyc_now;
  endtask

  task automatic test_full_frame();
    rom_mode = 1;
    for (int r = 0; r < ROWS_HALF; r++)
      for (int p = 0; p < 4; p++)
        check_rowplane(r, p, exp_on_cycles(p), 1'b0, -1);
    n_checks++;
    if (frame_start !== 1'b1 || (cyc_now - t_pref0) != FRAME_LEN)
      $display("FAIL frame_period got %0d cycles fs %b want %0d fs 1", cyc_now - t_pref0, frame_start, FRAME_LEN);
    else n_pass++;
  endtask

  task automatic test_plane_data();
    rom_mode = 0;
    for (int p = 0; p < 4; p++) check_rowplane(0, p, exp_on_cycles(p), (p == 0), -1);
  endtask

  task automatic test_enable_drop();
    int idle_err;
    idle_err = 0;
    rom_mode = 1;
    for (int r = 1; r < 3; r++)
      for (int p = 0; p < 4; p++) check_rowplane(r, p, exp_on_cycles(p), 1'b0, -1);
    check_rowplane(3, 0, exp_on_cycles(0), 1'b0, -1);
    check_rowplane(3, 1, exp_on_cycles(1), 1'b0, -1);
    check_rowplane(3, 2, exp_on_cycles(2), 1'b0, 10);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pan_oe_n !== 1'b1 || pan_clk !== 1'b0 || pan_lat !== 1'b0 || frame_start !== 1'b0 || pan_row !== 5'd3) idle_err++;
    end
    n_checks++;
    if (idle_err != 0) $display("FAIL idle_hold got %0d active cycles want 0", idle_err); else n_pass++;
    enable = 1'b1;
    tick();
    check_rowplane(3, 3, exp_on_cycles(3), 1'b0, -1);
  endtask

  task automatic test_reset_mid_display();
    int waited;
    waited = 0;
    while (pan_lat !== 1'b1 && waited < 200) begin tick(); waited++; end
    repeat (5) tick();
    n_checks++;
    if (pan_oe_n !== 1'b0) $display("FAIL mid_display_oe got %b want 0", pan_oe_n); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (pan_oe_n !== 1'b1 || pan_lat !== 1'b0) $display("FAIL midrst_ctl got oe %b lat %b want 1 0", pan_oe_n, pan_lat); else n_pass++;
    n_checks++;
    if (pan_row !== 5'd0 || rom_addr !== 11'd0) $display("FAIL midrst_addr got row %0d addr %h want 0 0", pan_row, rom_addr); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (frame_start !== 1'b1) $display("FAIL midrst_frame_start got %b want 1", frame_start); else n_pass++;
    tick();
`ifdef SCAN_BRIGHTNESS_EN
    brightness = 4'd7;
`endif
    for (int p = 0; p < 4; p++) check_rowplane(0, p, exp_on_cycles(p), 1'b0, -1);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog got %0d cycles want completion", cyc_now);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    check_rowplane(0, 0, exp_on_cycles(0), 1'b0, -1);
    for (int p = 1; p < 4; p++) check_rowplane(0, p, exp_on_cycles(p), 1'b0, -1);
    for (int r = 1; r < ROWS_HALF; r++)
      for (int p = 0; p < 4; p++) check_rowplane(r, p, exp_on_cycles(p), 1'b0, -1);
    n_checks++;
    if (frame_start !== 1'b1 || (cyc_now - t_pref0) != FRAME_LEN)
      $display("FAIL frame_period got %0d cycles fs %b want %0d fs 1", cyc_now - t_pref0, frame_start, FRAME_LEN);
    else n_pass++;
    test_plane_data();
    test_enable_drop();
    test_reset_mid_display();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
